// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared constants for the repeated-addition multiplier controller
package mul_pkg;

    localparam int WIDTH_DEF = 16;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_A = 3'd1;
    localparam logic [2:0] S_LOAD_B = 3'd2;
    localparam logic [2:0] S_ACC    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

endpackage

// File: rtl/mul_controller_if.sv
// rtl/mul_controller_if.sv - host/datapath signal bundle of the multiplier controller
interface mul_controller_if
    import mul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             eqz;
    logic             LdA;
    logic             LdB;
    logic             LdP;
    logic             clrP;
    logic             decB;
    logic [WIDTH-1:0] data_in;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] iter_count;

    // master is the controller; slave is the host plus datapath side
    modport master (
        input  start, abort, op_a, op_b, eqz,
        output LdA, LdB, LdP, clrP, decB, data_in, busy, done, err, iter_count
    );
    modport slave (
        output start, abort, op_a, op_b, eqz,
        input  LdA, LdB, LdP, clrP, decB, data_in, busy, done, err, iter_count
    );
endinterface

// File: rtl/mul_iter_cntr.sv
// rtl/mul_iter_cntr.sv - saturating counter with synchronous clear and increment
module mul_iter_cntr
    import mul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);
    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/mul_controller.sv
// rtl/mul_controller.sv - control FSM sequencing the repeated-addition multiplier datapath
module mul_controller
    import mul_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int MAX_ITER = 0
) (
    input  logic           clk,
    input  logic           rst,
    mul_controller_if.master bus
);
    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] iter_count;
    logic             accept;
    logic             guard_hit;
    logic             acc_step;

    assign accept    = (state_q == S_IDLE) && bus.start;
    assign guard_hit = (MAX_ITER != 0) && (iter_count == WIDTH'(MAX_ITER));
    assign acc_step  = (state_q == S_ACC) && !bus.eqz && !guard_hit;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.start) state_d = S_LOAD_A;
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: state_d = S_ACC;
            S_ACC: begin
                if (bus.eqz)       state_d = S_DONE;
                else if (guard_hit) state_d = S_ERR;
            end
            S_DONE:   state_d = S_IDLE;
            S_ERR:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (bus.abort && (state_q != S_IDLE)) state_d = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q <= bus.op_a;
                b_q <= bus.op_b;
            end
        end
    end

    mul_iter_cntr #(.WIDTH(WIDTH)) u_iter_cntr (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (accept),
        .inc_i   (acc_step),
        .count_o (iter_count)
    );

    // LdP/decB also see eqz so the final ACC cycle issues no strobe
    assign bus.LdA        = (state_q == S_LOAD_A);
    assign bus.LdB        = (state_q == S_LOAD_B);
    assign bus.clrP       = (state_q == S_LOAD_B);
    assign bus.LdP        = acc_step;
    assign bus.decB       = acc_step;
    assign bus.data_in    = (state_q == S_LOAD_A) ? a_q :
                            (state_q == S_LOAD_B) ? b_q : '0;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.err        = (state_q == S_ERR);
    assign bus.iter_count = iter_count;
endmodule
